// File: rtl/fc_event_pkg.sv
// Shared constants, the event ID type and the ID offset helper for the
// fabric-controller event serializer.
package fc_event_pkg;

  localparam int NB_EVENTS_DEF      = 64;
  localparam int EVENT_ID_WIDTH_DEF = 8;

  typedef logic [EVENT_ID_WIDTH_DEF-1:0] evt_id_t;

  // Full-width sum; the caller truncates to its own ID width.
  function automatic int unsigned evt_id_offset(input int unsigned base,
                                                input int unsigned idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/fc_evt_rr_pick.sv
// Combinational round-robin picker: lowest requester at or above ptr,
// wrapping to the lowest requester below ptr.
module fc_evt_rr_pick #(
  parameter int N  = 64,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;

  // Lower half holds requests at or above ptr, upper half all requests, so a
  // plain lowest-bit search over the concatenation gives the wrapped order.
  always_comb begin
    // NOTE: every output gets a default before the search so no latch is inferred.
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    dbl = {req, req & mask};
    for (int i = 0; i < 2 * N; i++) begin
      if (!gnt_valid && dbl[i]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(i % N);
      end
    end
  end

endmodule

// File: rtl/fc_event_serializer.sv
// Buffers one pending flag per event source and serializes them round-robin
// into event IDs over a valid/fulln FIFO handshake, flagging dropped events.
module fc_event_serializer
  import fc_event_pkg::*;
#(
  parameter int NB_EVENTS      = NB_EVENTS_DEF,
  parameter int EVENT_ID_WIDTH = EVENT_ID_WIDTH_DEF,
  parameter int EVT_ID_BASE    = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NB_EVENTS-1:0]      events_i,
  output logic                      event_fifo_valid_o,
  input  logic                      event_fifo_fulln_i,
  output logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o,
  output logic                      lost_o,
  output logic                      lost_sticky_o,
  input  logic                      lost_clr_i,
  output logic                      busy_o
);

  localparam int IDX_W = (NB_EVENTS > 1) ? $clog2(NB_EVENTS) : 1;

  if (NB_EVENTS < 1 || EVT_ID_BASE < 0 ||
      (longint'(EVT_ID_BASE) + longint'(NB_EVENTS)) > (longint'(1) << EVENT_ID_WIDTH))
  begin : g_param_check
    $error("fc_event_serializer: EVT_ID_BASE + NB_EVENTS - 1 must fit in EVENT_ID_WIDTH bits");
  end

  logic [NB_EVENTS-1:0]      pending_q, pending_d, gnt_onehot, drop_vec;
  logic [IDX_W-1:0]          ptr_q, ptr_d, gnt_idx;
  logic                      gnt_valid, loadable, grant;
  logic                      valid_q, valid_d, lost_q, lost_d, sticky_q, sticky_d;
  logic [EVENT_ID_WIDTH-1:0] data_q, data_d;

  fc_evt_rr_pick #(.N(NB_EVENTS), .IW(IDX_W)) u_pick (
    .req       (pending_q),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    loadable   = !valid_q || event_fifo_fulln_i;
    grant      = loadable && gnt_valid;
    gnt_onehot = '0;
    if (grant) gnt_onehot[gnt_idx] = 1'b1;

    // A pulse on the source being granted re-arms it; any other pulse on a
    // set pending bit has nowhere to go.
    drop_vec  = events_i & pending_q & ~gnt_onehot;
    pending_d = (pending_q & ~gnt_onehot) | events_i;
    lost_d    = |drop_vec;
    sticky_d  = lost_d || (sticky_q && !lost_clr_i);

    valid_d = loadable ? gnt_valid : valid_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    if (grant) begin
      data_d = EVENT_ID_WIDTH'(evt_id_offset(32'(EVT_ID_BASE), 32'(gnt_idx)));
      ptr_d  = (int'(gnt_idx) == NB_EVENTS - 1) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      ptr_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      lost_q    <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      lost_q    <= lost_d;
      sticky_q  <= sticky_d;
    end
  end

  assign event_fifo_valid_o = valid_q;
  assign event_fifo_data_o  = data_q;
  assign lost_o             = lost_q;
  assign lost_sticky_o      = sticky_q;
  assign busy_o             = (|pending_q) || valid_q;

endmodule

// File: tb/tb_fc_event_serializer.sv
// Directed bench for fc_event_serializer: a queue/array reference model is
// compared every cycle, plus literal expectations for each scenario.
module tb_fc_event_serializer;
  import fc_event_pkg::*;

  localparam int N = 64;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic [N-1:0] events   = '0;
  logic         fulln    = 1'b1;
  logic         lost_clr = 1'b0;
  logic         valid, lost, sticky, busy;
  evt_id_t      data;

  int checks   = 0;
  int errors   = 0;
  int lost_cnt = 0;

  always #5 clk = ~clk;

  fc_event_serializer #(.NB_EVENTS(N), .EVENT_ID_WIDTH(8), .EVT_ID_BASE(0)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .events_i           (events),
    .event_fifo_valid_o (valid),
    .event_fifo_fulln_i (fulln),
    .event_fifo_data_o  (data),
    .lost_o             (lost),
    .lost_sticky_o      (sticky),
    .lost_clr_i         (lost_clr),
    .busy_o             (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending flags as an array, output entry as plain values.
  logic [N-1:0] m_pend;
  int           m_ptr;
  logic         m_valid;
  int           m_data;
  logic         m_lost, m_sticky;
  int           m_xfer[$];
  int           d_xfer[$];

  always @(posedge clk or negedge rst_n) begin : model
    int   g;
    int   k;
    logic drop;
    logic open;
    if (!rst_n) begin
      m_pend   <= '0;
      m_ptr    <= 0;
      m_valid  <= 1'b0;
      m_data   <= 0;
      m_lost   <= 1'b0;
      m_sticky <= 1'b0;
    end else begin
      g    = -1;
      drop = 1'b0;
      open = !m_valid || fulln;
      if (m_valid && fulln) m_xfer.push_back(m_data);
      if (open) begin
        for (int j = 0; j < N; j++) begin
          k = (m_ptr + j) % N;
          if (g < 0 && m_pend[k]) g = k;
        end
      end
      for (int s = 0; s < N; s++) begin
        if (events[s] && m_pend[s] && s != g) drop = 1'b1;
      end
      for (int s = 0; s < N; s++) begin
        m_pend[s] <= events[s] || (m_pend[s] && s != g);
      end
      if (open) m_valid <= (g >= 0);
      if (g >= 0) begin
        m_data <= g;
        m_ptr  <= (g + 1) % N;
      end
      m_lost   <= drop;
      m_sticky <= drop || (m_sticky && !lost_clr);
    end
  end

  always @(negedge clk) begin
    check("valid", 32'(valid), 32'(m_valid));
    if (m_valid) check("data", 32'(data), 32'(m_data));
    check("lost", 32'(lost), 32'(m_lost));
    check("sticky", 32'(sticky), 32'(m_sticky));
    check("busy", 32'(busy), 32'((|m_pend) || m_valid));
    if (valid && fulln) d_xfer.push_back(int'(data));
    if (lost) lost_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Compares both the DUT and model transfer logs against literal IDs, then clears them.
  task automatic check_seq(input string name, input int n,
                           input int e0 = 0, input int e1 = 0, input int e2 = 0);
    int e[3];
    e = '{e0, e1, e2};
    check($sformatf("%s_count", name), 32'(d_xfer.size()), 32'(n));
    check($sformatf("%s_model_count", name), 32'(m_xfer.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < d_xfer.size()) check($sformatf("%s_id%0d", name, i), 32'(d_xfer[i]), 32'(e[i]));
      if (i < m_xfer.size()) check($sformatf("%s_model_id%0d", name, i), 32'(m_xfer[i]), 32'(e[i]));
    end
    d_xfer.delete();
    m_xfer.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", 32'(valid), 0);
    check("rst_data", 32'(data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sticky", 32'(sticky), 0);
    rst_n = 1'b1;
    tick; tick;

    // Single event: visible two cycles after the pulse, for one cycle.
    events[5] = 1'b1;
    tick; events = '0;
    #1 check("single_t1_valid", 32'(valid), 0);
    tick;
    #1 check("single_t2_valid", 32'(valid), 1);
    check("single_t2_data", 32'(data), 5);
    tick;
    #1 check("single_t3_valid", 32'(valid), 0);
    check("single_t3_busy", 32'(busy), 0);
    check_seq("single", 1, 5);

    // Grant 63 so the pointer wraps to 0, then a three-source burst.
    events[63] = 1'b1;
    tick; events = '0;
    repeat (3) tick;
    check_seq("wrap", 1, 63);
    events[0] = 1'b1; events[3] = 1'b1; events[63] = 1'b1;
    tick; events = '0;
    tick; #1 check("burst_c0", 32'(data), 0);
    tick; #1 check("burst_c1", 32'(data), 3);
    tick; #1 check("burst_c2", 32'(data), 63);
    check("burst_c2_valid", 32'(valid), 1);
    tick;
    check_seq("burst", 3, 0, 3, 63);
    events[0] = 1'b1; events[3] = 1'b1;
    tick; events = '0;
    repeat (3) tick;
    check_seq("burst2", 2, 0, 3);

    // Back-pressure: entry 7 holds while 9 waits behind it.
    fulln = 1'b0;
    events[7] = 1'b1;
    tick; events = '0;
    tick;
    #1 check("bp_load_data", 32'(data), 7);
    events[9] = 1'b1;
    tick; events = '0;
    repeat (3) tick;
    #1 check("bp_hold_valid", 32'(valid), 1);
    check("bp_hold_data", 32'(data), 7);
    check_seq("bp_hold", 0);
    fulln = 1'b1;
    tick;
    #1 check("bp_next_data", 32'(data), 9);
    tick;
    #1 check("bp_drain_valid", 32'(valid), 0);
    check_seq("bp", 2, 7, 9);

    // Loss: second pulse on a still-pending source under back-pressure.
    lost_cnt = 0;
    fulln = 1'b0;
    events[8] = 1'b1;
    tick; events = '0; events[2] = 1'b1;
    tick; events = '0;
    tick; tick;
    events[2] = 1'b1;
    tick; events = '0;
    #1 check("loss_pulse", 32'(lost), 1);
    check("loss_sticky", 32'(sticky), 1);
    tick;
    #1 check("loss_pulse_end", 32'(lost), 0);
    check("loss_sticky_hold", 32'(sticky), 1);
    events[2] = 1'b1; lost_clr = 1'b1;
    tick; events = '0; lost_clr = 1'b0;
    #1 check("loss_set_wins", 32'(sticky), 1);
    lost_clr = 1'b1;
    tick; lost_clr = 1'b0;
    #1 check("loss_cleared", 32'(sticky), 0);
    fulln = 1'b1;
    repeat (4) tick;
    check_seq("loss", 2, 8, 2);
    check("loss_pulses", 32'(lost_cnt), 2);

    // Same-cycle re-arm: pulse while the pending bit is being granted.
    lost_cnt = 0;
    events[4] = 1'b1;
    tick;
    tick; events = '0;
    repeat (4) tick;
    check_seq("rearm", 2, 4, 4);
    check("rearm_no_loss", 32'(lost_cnt), 0);

    // Reset mid-operation with ten pending events and a valid entry.
    fulln = 1'b0;
    events = 64'h0000_0000_000F_FC00;
    tick; events = '0;
    repeat (2) tick;
    #1 check("rst_mid_valid_before", 32'(valid), 1);
    check("rst_mid_busy_before", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_valid", 32'(valid), 0);
    check("rst_mid_busy", 32'(busy), 0);
    tick;
    rst_n = 1'b1;
    fulln = 1'b1;
    repeat (10) tick;
    check_seq("post_rst", 0);
    events[1] = 1'b1; events[63] = 1'b1;
    tick; events = '0;
    repeat (4) tick;
    check_seq("ptr_rst", 2, 1, 63);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
